// File: rtl/debounce_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge_pkg
// Description : Shared definitions for the switch debouncer: FSM state
//               encoding and the default debounce counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_edge_pkg;

    // Default counter width; the stable interval is 2**N clock cycles.
    localparam int c_N_DEFAULT = 20;

    // Debouncer FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ZERO  = 2'd0;  // debounced low, input agrees
    localparam state_t c_WAIT1 = 2'd1;  // debounced low, input high, timing
    localparam state_t c_ONE   = 2'd2;  // debounced high, input agrees
    localparam state_t c_WAIT0 = 2'd3;  // debounced high, input low, timing

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer that brings an asynchronous level into
//               the clk domain.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset, clears both flops
//               d     - asynchronous input level
//               q     - synchronized output (second flop)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= d;
            r_sync2 <= r_sync1;
        end
    end

    assign q = r_sync2;

endmodule
`default_nettype wire

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge
// Description : Switch/pushbutton debouncer. The raw level is synchronized,
//               then a four-state FSM requires the synchronized level to stay
//               at its new value for the whole 2**N-cycle interval before the
//               debounced level follows. A one-cycle tick marks each
//               debounced rising transition.
// Ports       : clk      - system clock, rising-edge active
//               reset    - synchronous active-high reset
//               sw       - raw asynchronous switch level
//               db_level - debounced level (registered FSM decode)
//               db_tick  - one-cycle pulse on debounced 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int N = c_N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam logic [N-1:0] c_CNT_FULL = {N{1'b1}};

    logic         w_sw_s;
    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_cnt;
    logic [N-1:0] w_cnt_nxt;
    logic         r_tick;
    logic         w_tick_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (w_sw_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ZERO;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Each WAIT state needs the counter to reach zero and then one more
    // agreeing sample, so a full 2**N agreeing samples after the load edge.
    // Any disagreeing sample abandons the wait; re-entry reloads the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tick_nxt  = 1'b0;
        case (r_state)
            c_ZERO: begin
                if (w_sw_s) begin
                    w_state_nxt = c_WAIT1;
                    w_cnt_nxt   = c_CNT_FULL;
                end
            end
            c_WAIT1: begin
                if (!w_sw_s) begin
                    w_state_nxt = c_ZERO;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ONE;
                    w_tick_nxt  = 1'b1;   // only the WAIT1->ONE path pulses
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ONE: begin
                if (!w_sw_s) begin
                    w_state_nxt = c_WAIT0;
                    w_cnt_nxt   = c_CNT_FULL;
                end
            end
            c_WAIT0: begin
                if (w_sw_s) begin
                    w_state_nxt = c_ONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ZERO;
            end
        endcase
    end

    assign db_level = (r_state == c_ONE) || (r_state == c_WAIT0);
    assign db_tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_edge
// Description : Self-checking bench for debounce_edge with N=4. A fixed vector
//               table covers reset and the basic rise latency, hand-written
//               sequences cover bounce, glitches, falling edge and reset
//               during a wait, and a random phase runs against a reference
//               model that tracks how long the synchronized input has
//               disagreed with the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge;

    localparam int c_N   = 4;
    localparam int c_LAT = (2 ** c_N) + 2;   // capture edge to output edge

    logic clk;
    logic reset;
    logic sw;
    logic db_level;
    logic db_tick;

    debounce_edge #(.N(c_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int n_tick = 0;
    int last_tick = -1;

    // Reference model: a two-sample input delay, and a run length of
    // consecutive samples that disagree with the debounced level.
    logic m_d1, m_d2;
    logic m_level, m_tick;
    int   m_run;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
        end
    endtask

    task automatic model_edge(input logic swv, input logic rv);
        logic s;
        if (rv) begin
            m_d1 = 1'b0; m_d2 = 1'b0;
            m_level = 1'b0; m_tick = 1'b0; m_run = 0;
        end else begin
            s = m_d2;
            m_tick = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == (2 ** c_N) + 1) begin
                    m_level = s;
                    m_tick  = s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = swv;
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare after it.
    task automatic step(input logic swv, input logic rv);
        sw    = swv;
        reset = rv;
        @(posedge clk);
        model_edge(swv, rv);
        cyc++;
        #1;
        check("model_level", int'(db_level), int'(m_level));
        check("model_tick",  int'(db_tick),  int'(m_tick));
        if (db_tick) begin
            n_tick++;
            last_tick = cyc;
        end
    endtask

    typedef struct {
        logic sw;
        logic rst;
        logic exp_level;
        logic exp_tick;
    } vec_t;

    localparam int c_NV = 24;
    vec_t vt[c_NV];

    initial begin : main
        int cap, t0, fall_at;
        logic saw_high, saw_low;
        sw = 1'b0;
        reset = 1'b1;
        m_d1 = 0; m_d2 = 0; m_level = 0; m_tick = 0; m_run = 0;

        // Vector table: two reset cycles, then sw held high from edge 2.
        // That edge captures the 1, so the rise shows after edge 2+c_LAT.
        for (int i = 0; i < c_NV; i++) begin
            vt[i].rst       = (i < 2);
            vt[i].sw        = (i >= 2);
            vt[i].exp_level = (i >= 2 + c_LAT);
            vt[i].exp_tick  = (i == 2 + c_LAT);
        end
        for (int i = 0; i < c_NV; i++) begin
            step(vt[i].sw, vt[i].rst);
            check("table_level", int'(db_level), int'(vt[i].exp_level));
            check("table_tick",  int'(db_tick),  int'(vt[i].exp_tick));
        end

        // Bounce: toggle every 3 cycles for 40 cycles, then hold high.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        t0 = n_tick;
        for (int i = 0; i < 40; i++) step(((i / 3) % 2) == 0, 1'b0);
        step(1'b1, 1'b0);
        cap = cyc;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        check("bounce_tick_count", n_tick - t0, 1);
        check("bounce_tick_time", last_tick, cap + c_LAT);

        // Short low glitch while in ONE: level holds, no tick.
        t0 = n_tick;
        saw_low = 1'b0;
        for (int i = 0; i < 35; i++) begin
            step(i >= 10, 1'b0);
            if (!db_level) saw_low = 1'b1;
        end
        check("glitch_low_level_held", int'(saw_low), 0);
        check("glitch_low_no_tick", n_tick - t0, 0);

        // Falling edge: sw low held, level falls c_LAT edges after capture.
        t0 = n_tick;
        fall_at = -1;
        step(1'b0, 1'b0);
        cap = cyc;
        if (!db_level) fall_at = cyc;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b0);
            if (!db_level && fall_at < 0) fall_at = cyc;
        end
        check("fall_time", fall_at, cap + c_LAT);
        check("fall_no_tick", n_tick - t0, 0);

        // Reset pulsed during WAIT1 with sw held high.
        step(1'b0, 1'b1);
        t0 = n_tick;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("wait_reset_level", int'(db_level), 0);
        check("wait_reset_tick",  int'(db_tick), 0);
        check("wait_reset_no_early_tick", n_tick - t0, 0);
        step(1'b1, 1'b0);
        cap = cyc;
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        check("rerun_tick_count", n_tick - t0, 1);
        check("rerun_tick_time", last_tick, cap + c_LAT);

        // Exactly 15 stable high cycles must not get through.
        step(1'b0, 1'b1);
        t0 = n_tick;
        saw_high = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step(i < 15, 1'b0);
            if (db_level) saw_high = 1'b1;
        end
        check("short_pulse_level", int'(saw_high), 0);
        check("short_pulse_tick", n_tick - t0, 0);

        // Random runs of random length, with occasional resets.
        for (int r = 0; r < 300; r++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) step(v, ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 The block SHALL take parameter N, default 20, as the debounce counter width; the stable interval is 2^N clock cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port sw, input, 1 bit: raw, asynchronous, bouncing switch or pushbutton level.
REQ-005 The block SHALL have port db_level, output, 1 bit: debounced level, intended as the d input of the downstream D flip-flop.
REQ-006 The block SHALL have port db_tick, output, 1 bit: one-cycle pulse on each debounced 0->1 transition.

Function
REQ-007 sw SHALL pass through a two-flop synchronizer (sync1 -> sync2); only sync2 (sw_s) SHALL feed the FSM.
REQ-008 The FSM SHALL have states ZERO, WAIT1, ONE, WAIT0.
REQ-009 In ZERO with sw_s=1, the FSM SHALL go to WAIT1 and load the counter with 2^N-1; otherwise it SHALL stay in ZERO.
REQ-010 In WAIT1 with sw_s=0, the FSM SHALL return to ZERO; otherwise it SHALL decrement the counter.
REQ-011 In WAIT1 with counter=0 and sw_s=1, the FSM SHALL go to ONE.
REQ-012 In ONE with sw_s=0, the FSM SHALL go to WAIT0 and load the counter with 2^N-1; otherwise it SHALL stay in ONE.
REQ-013 In WAIT0 with sw_s=1, the FSM SHALL return to ONE; otherwise it SHALL decrement the counter.
REQ-014 In WAIT0 with counter=0 and sw_s=0, the FSM SHALL go to ZERO.
REQ-015 db_level SHALL be Moore: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-016 db_tick SHALL be 1 only in the first cycle after entering ONE from WAIT1; a return WAIT0->ONE SHALL NOT pulse.
REQ-017 Latency: let edge k be the edge where sync1 first captures a stable 1; db_level SHALL rise in the cycle following edge k+2^N+2 (18 cycles for N=4), with db_tick high in that same cycle only.
REQ-018 Falling latency SHALL be symmetric: db_level falls 2^N+2 edges after sync1 captures a stable 0.
REQ-019 Any sw_s excursion shorter than 2^N cycles SHALL leave db_level unchanged and SHALL produce no db_tick.
REQ-020 The counter SHALL be an N-bit unsigned value; it SHALL NOT decrement below 0 and SHALL NOT wrap.
REQ-021 Restarting a WAIT state SHALL reload the counter to the full 2^N-1; no partial credit is kept.

Reset
REQ-022 With reset=1 at a clk edge, the block SHALL set state=ZERO, counter=0, sync1=sync2=0, db_level=0 and db_tick=0, overriding every other transition.
REQ-023 Reset asserted mid-WAIT1 or mid-WAIT0 SHALL abort the wait with no db_tick.
REQ-024 If sw is held high across reset release, the block SHALL debounce it normally per REQ-017, counting from the first post-reset edge.

Structure
REQ-025 A shared package SHALL hold the state enumeration (ZERO, WAIT1, ONE, WAIT0) and the default N.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, reset, d and q, using the same synchronous reset.
REQ-027 State, counter and db_tick SHALL be registered; there SHALL be no combinational path from sw to any output.

Verification
REQ-028 (N=4) Reset, then sw=1 held: db_level rises exactly 18 cycles after sync1 captures 1; db_tick high for exactly 1 cycle, aligned with the rise.
REQ-029 (N=4) Bounce: sw toggles every 3 cycles for 40 cycles, then stays 1: exactly one db_tick, 18 cycles after the final rise is captured.
REQ-030 (N=4) In ONE, sw=0 for 10 cycles, then sw=1: db_level stays 1 and db_tick stays 0.
REQ-031 (N=4) sw held 1, reset pulsed 1 cycle during WAIT1 (8 cycles in): outputs are 0 the cycle after reset; db_tick occurs 18 cycles after re-capture.
REQ-032 (N=4) In ONE, sw=0 held: db_level falls 18 cycles after capture; no db_tick at any point.
REQ-033 (N=4) sw=1 for exactly 15 stable cycles, then 0: db_level never rises and db_tick never asserts.
